// File: rtl/rv_mem_pkg.sv
// Shared load/store definitions: size encodings, responder FSM states,
// byte-enable / lane-replication helpers and the load-extension function.
package rv_mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t IDLE = 2'd0;
  localparam mem_state_t WAIT = 2'd1;
  localparam mem_state_t RESP = 2'd2;

  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] offset);
    byte_enable = 4'b0000;
    case (size)
      MEM_B:   byte_enable = 4'b0001 << offset;
      MEM_H:   byte_enable = 4'b0011 << offset;
      MEM_W:   byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied onto every lane the byte enable may pick.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    store_lanes = wdata;
    case (size)
      MEM_B:   store_lanes = {4{wdata[7:0]}};
      MEM_H:   store_lanes = {2{wdata[15:0]}};
      default: store_lanes = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  offset,
                                              input logic        is_unsigned);
    logic [31:0] shifted;
    shifted     = word >> {offset, 3'b000};
    load_extend = word;
    case (size)
      MEM_B: load_extend = is_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H: load_extend = is_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read-first: a write cycle returns the old word.
module dmem_ram_be #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // rdata only moves when enabled, so a captured word survives the wait states.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store path: one request at a time
// over valid/ready, byte-lane RAM, configurable read latency, busy for stalls.
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  mem_state_t  state;
  logic [3:0]  wait_cnt;
  logic        accept;
  logic        req_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        we_q;
  logic        err_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic [31:0] resp_data;
  logic [31:0] hold_rdata;
  logic        hold_err;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready && !reset;

  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11) req_err = 1'b1;
    if (req_size == MEM_H && req_addr[0]) req_err = 1'b1;
    if (req_size == MEM_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ((req_addr >> (ADDR_W + 2)) != 32'd0) req_err = 1'b1;
  end

  // Faulty requests never touch the RAM, neither to write nor to read.
  assign ram_en    = accept && !req_err;
  assign ram_we    = (ram_en && req_we) ? byte_enable(req_size, req_addr[1:0]) : 4'b0000;
  assign ram_wdata = store_lanes(req_size, req_wdata);

  dmem_ram_be #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (req_addr[ADDR_W+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign resp_data = (err_q || we_q) ? 32'd0
                                     : load_extend(ram_rdata, size_q, offset_q, unsigned_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= MEM_B;
      offset_q   <= 2'b00;
      hold_rdata <= 32'd0;
      hold_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            err_q      <= req_err;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            offset_q   <= req_addr[1:0];
            if (req_err || req_we || WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_LOAD);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state      <= IDLE;
          hold_rdata <= resp_data;
          hold_err   <= err_q;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outside the response cycle the last response is replayed unchanged.
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rsp_valid ? resp_data : hold_rdata;
  assign rsp_err   = rsp_valid ? err_q : hold_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the pipelined RISC-V core's load/store path: the memory end of the EX/MEM memory interface the pipeline drives.
- Accepts one load/store request at a time over a valid/ready handshake.
- Services it from an internal word-organised RAM with byte lanes, with configurable read latency.
- Returns a sign- or zero-extended load result or a store acknowledge.
- Provides a busy signal the hazard unit uses to stall the pipeline.

Parameters:
ADDR_W, 10, word-address bits; RAM depth = 2^ADDR_W 32-bit words
WAIT_CYCLES, 1, extra read-latency cycles, legal 0..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends (LBU/LHU) when 1
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_ready  out  1  responder can accept
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size or out-of-range; valid with rsp_valid
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0. req_ready = (state==IDLE), so it reads 1 in the first cycle after reset. RAM contents are not reset.
- Accept: a request is taken on a rising edge where req_valid && req_ready. Address, size, unsigned flag and byte offset are registered.
- Error conditions, evaluated at accept:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:ADDR_W+2] != 0
  - On error: no RAM write; go to RESP; the response carries rsp_err=1 and rsp_rdata=0.
- Store:
  - RAM is written on the accept edge at word addr[ADDR_W+1:2].
  - Byte enable = 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word. Data lanes are replicated to match.
  - Then RESP: rsp_valid one cycle after accept, rsp_rdata=0.
- Load:
  - The RAM read is synchronous; the word is captured on the accept edge.
  - If WAIT_CYCLES=0, go to RESP. Otherwise go to WAIT with the counter loaded to WAIT_CYCLES-1. WAIT decrements each cycle and moves to RESP when the counter is 0.
  - rsp_valid asserts exactly WAIT_CYCLES+1 cycles after the accept edge.
  - The byte or half is selected by the registered addr[1:0] and extended per req_unsigned.
- FSM: IDLE -> (accept) -> WAIT or RESP; WAIT -> RESP; RESP -> IDLE unconditionally. There is no response back-pressure; the core always consumes the pulse.
- Throughput: a new accept is possible in the cycle after RESP. Minimum spacing is 2 cycles for stores and WAIT_CYCLES+2 cycles for loads.
- req_valid held while req_ready=0 is ignored; the requester must hold the request stable until accepted.
- Holding outputs: rsp_rdata/rsp_err hold their last value when rsp_valid=0. Only rsp_valid is the qualifier.
- Reset mid-transaction: return to IDLE next edge, drop any pending response, rsp_valid=0. A store already accepted remains committed.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

Decomposition:
- Shared package rv_mem_pkg:
  - size encodings MEM_B/MEM_H/MEM_W
  - FSM state typedef {IDLE, WAIT, RESP}
  - byte-enable generation function
  - load-extension function (also usable by the pipeline's WB path)
- One sub-module, dmem_ram_be: 2^ADDR_W x 32 single-port synchronous RAM with 4-bit byte-write enable and read-first behaviour.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 with WAIT_CYCLES=1 -> load rsp_valid exactly 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte loads @0x10..0x13 from word 0xDEADBEEF: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
- SB 0x5A @0x11 over 0xDEADBEEF -> subsequent LW @0x10 returns 0xDEAD5AEF.
- Errors: LW @0x12, LH @0x13, size 11, and address 0x00001000 with ADDR_W=10 -> each gives rsp_err=1 and rsp_rdata=0; a following LW @0x10 proves the RAM is unchanged.
- Back-to-back: req_valid held high with 3 loads, WAIT_CYCLES=2 -> accepts spaced exactly 4 cycles, busy high between them, req_ready low during WAIT/RESP.
- Reset asserted in the WAIT cycle of a load -> no rsp_valid; req_ready=1 the cycle after reset deasserts. A store accepted just before reset reads back correctly.
